// File: rtl/frame_capture_writer.sv
// Samples an OV7670-style byte stream in the CLK domain and writes RGB332 pixels to a row-major
// framebuffer. Define FRAME_CAPTURE_TEST_PATTERN_EN to add a TEST_MODE colour-bar override.
module frame_capture_writer #(
  parameter int unsigned WIDTH  = 176,
  parameter int unsigned HEIGHT = 144,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned MODE   = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
  input  logic              TEST_MODE,
`endif
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic [7:0]        FRAME_COUNT,
  output logic              OVERFLOW
);

  localparam int unsigned X_W    = $clog2(WIDTH + 1);
  localparam int unsigned Y_W    = $clog2(HEIGHT + 1);
  localparam int unsigned SYNC_W = 11;
  localparam logic [X_W-1:0]    X_MAX    = X_W'(WIDTH);
  localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
  localparam logic [X_W-1:0]    BAR1     = X_W'(WIDTH / 3);
  localparam logic [X_W-1:0]    BAR2     = X_W'((2 * WIDTH) / 3);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;

  state_t              r_state;
  logic [SYNC_W-1:0]   r_sync1, r_sync2;
  logic                r_pclk_hist, r_href_hist, r_vsync_hist;
  logic                r_ev_pix, r_ev_line, r_ev_vfall, r_ev_vrise;
  logic [7:0]          r_ev_data;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [ADDR_W-1:0]   r_row_base;
  logic                r_phase, r_line_pix;
  logic [7:0]          r_b1;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [7:0]          r_wr_data;

  logic                w_pclk, w_href, w_vsync;
  logic [7:0]          w_data;
  logic                w_pix_valid, w_in_frame;
  logic [7:0]          w_pix_data;

  assign w_pclk     = r_sync2[10];
  assign w_href     = r_sync2[9];
  assign w_vsync    = r_sync2[8];
  assign w_data     = r_sync2[7:0];
  assign w_in_frame = (r_x < X_MAX) && (r_y < Y_MAX);

  // Two-flop synchroniser, history flop and one registered event stage
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_pclk_hist  <= 1'b0;
      r_href_hist  <= 1'b0;
      r_vsync_hist <= 1'b0;
      r_ev_pix     <= 1'b0;
      r_ev_line    <= 1'b0;
      r_ev_vfall   <= 1'b0;
      r_ev_vrise   <= 1'b0;
      r_ev_data    <= '0;
    end else begin
      r_sync1      <= {CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_DATA};
      r_sync2      <= r_sync1;
      r_pclk_hist  <= w_pclk;
      r_href_hist  <= w_href;
      r_vsync_hist <= w_vsync;
      r_ev_pix     <= w_pclk && !r_pclk_hist && w_href;
      r_ev_line    <= !w_href && r_href_hist;
      r_ev_vfall   <= !w_vsync && r_vsync_hist;
      r_ev_vrise   <= w_vsync && !r_vsync_hist;
      r_ev_data    <= w_data;
    end
  end

  // Pixel assembly: RGB565 byte pair -> RGB332, or native RGB332 byte
  always_comb begin
    w_pix_valid = r_ev_pix;
    w_pix_data  = r_ev_data;
    if (MODE == 0) begin
      w_pix_valid = r_ev_pix && r_phase;
      w_pix_data  = {r_b1[7:5], r_b1[2:0], r_ev_data[4:3]};
    end
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
    if (TEST_MODE) begin
      if (r_x < BAR1)      w_pix_data = 8'b111_000_00;
      else if (r_x < BAR2) w_pix_data = 8'b000_111_00;
      else                 w_pix_data = 8'b000_000_11;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_row_base  <= '0;
      r_phase     <= 1'b0;
      r_line_pix  <= 1'b0;
      r_b1        <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      W_EN        <= 1'b0;
      W_ADDR      <= '0;
      W_DATA      <= '0;
      FRAME_DONE  <= 1'b0;
      FRAME_COUNT <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      FRAME_DONE <= 1'b0;
      W_EN       <= r_wr_en;
      W_ADDR     <= r_wr_addr;
      W_DATA     <= r_wr_data;
      case (r_state)
        ST_IDLE: begin
          if (r_ev_vfall) begin
            r_state    <= ST_CAPTURE;
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
            r_phase    <= 1'b0;
            r_line_pix <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (r_ev_pix && (MODE == 0) && !r_phase) begin
            r_b1    <= r_ev_data;
            r_phase <= 1'b1;
          end
          if (w_pix_valid) begin
            r_phase    <= 1'b0;
            r_line_pix <= 1'b1;
            if (w_in_frame) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_row_base + ADDR_W'(r_x);
              r_wr_data <= w_pix_data;
              r_x       <= r_x + 1'b1;
            end else begin
              OVERFLOW <= 1'b1;
            end
          end
          // Line end: a dangling first byte is lost; empty lines do not advance Y
          if (r_ev_line) begin
            r_x        <= '0;
            r_phase    <= 1'b0;
            r_line_pix <= 1'b0;
            if (r_phase) OVERFLOW <= 1'b1;
            if (r_line_pix) begin
              if (r_y < Y_MAX) begin
                r_y        <= r_y + 1'b1;
                r_row_base <= r_row_base + ROW_STEP;
              end else begin
                OVERFLOW <= 1'b1;
              end
            end
          end
          if (r_ev_vrise) r_state <= ST_DONE;
        end
        ST_DONE: begin
          FRAME_DONE  <= 1'b1;
          FRAME_COUNT <= FRAME_COUNT + 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
